// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and helpers for the SPI transfer sequencer
package spi_pkg;

  localparam int SPI_BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_GAP  = 2'd2
  } xfer_state_t;

  // Occupancy needs one extra bit so that "full" (== depth) is representable.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead synchronous FIFO with occupancy output
// Push while full is accepted only when a pop happens on the same clk.
module sync_fifo
  import spi_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_push,
  input  logic [DATA_W-1:0]         i_wdata,
  input  logic                      i_pop,
  output logic [DATA_W-1:0]         o_rdata,
  output logic                      o_full,
  output logic                      o_empty,
  output logic [level_w(DEPTH)-1:0] o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = level_w(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [LW-1:0]     r_level;
  logic              w_do_push;
  logic              w_do_pop;

  assign o_level   = r_level;
  assign o_full    = (r_level == LW'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_rdata   = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_do_push && !w_do_pop) begin
        r_level <= r_level + LW'(1);
      end else if (!w_do_push && w_do_pop) begin
        r_level <= r_level - LW'(1);
      end
    end
  end

endmodule

// File: rtl/spi_xfer_sequencer.sv
// rtl/spi_xfer_sequencer.sv - byte-stream front end that launches one SPI master transfer per byte
// One transfer in flight at a time; an RX slot is reserved before each launch.
module spi_xfer_sequencer
  import spi_pkg::*;
#(
  parameter int DEPTH          = 8,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [SPI_BYTE_W-1:0]     i_tx_data,
  input  logic                      i_tx_valid,
  output logic                      o_tx_ready,
  output logic [SPI_BYTE_W-1:0]     o_rx_data,
  output logic                      o_rx_valid,
  input  logic                      i_rx_ready,
  output logic                      o_spi_start,
  output logic [SPI_BYTE_W-1:0]     o_spi_tx_byte,
  input  logic [SPI_BYTE_W-1:0]     i_spi_rx_byte,
  input  logic                      i_spi_done,
  output logic                      o_busy,
  output logic                      o_timeout_err,
  input  logic                      i_err_clr,
  output logic [level_w(DEPTH)-1:0] o_tx_level,
  output logic [level_w(DEPTH)-1:0] o_rx_level
);

  localparam int GW       = $clog2(GAP_CYCLES + 2);
  localparam int TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  xfer_state_t           r_state;
  logic                  r_spi_start;
  logic [SPI_BYTE_W-1:0] r_spi_tx_byte;
  logic                  r_timeout_err;
  logic [GW-1:0]         r_gap_cnt;
  logic [TW-1:0]         r_tmo_cnt;

  logic                  w_tx_empty;
  logic                  w_tx_full;
  logic [SPI_BYTE_W-1:0] w_tx_head;
  logic                  w_tx_pop;
  logic                  w_tx_ready;
  logic                  w_rx_empty;
  logic                  w_rx_full;
  logic                  w_rx_push;

  // Launch only when the RX FIFO can absorb the reply, so RX never overflows.
  assign w_tx_pop   = (r_state == ST_IDLE) & ~w_tx_empty & ~w_rx_full;
  assign w_tx_ready = ~w_tx_full | w_tx_pop;
  assign w_rx_push  = (r_state == ST_WAIT) & i_spi_done;

  assign o_tx_ready    = w_tx_ready;
  assign o_rx_valid    = ~w_rx_empty;
  assign o_spi_start   = r_spi_start;
  assign o_spi_tx_byte = r_spi_tx_byte;
  assign o_timeout_err = r_timeout_err;
  assign o_busy        = (r_state != ST_IDLE) | ~w_tx_empty;

  sync_fifo #(.DATA_W(SPI_BYTE_W), .DEPTH(DEPTH)) u_tx_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (i_tx_valid & w_tx_ready),
    .i_wdata (i_tx_data),
    .i_pop   (w_tx_pop),
    .o_rdata (w_tx_head),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty),
    .o_level (o_tx_level)
  );

  sync_fifo #(.DATA_W(SPI_BYTE_W), .DEPTH(DEPTH)) u_rx_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_rx_push),
    .i_wdata (i_spi_rx_byte),
    .i_pop   (i_rx_ready),
    .o_rdata (o_rx_data),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty),
    .o_level (o_rx_level)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= ST_IDLE;
      r_spi_start   <= 1'b0;
      r_spi_tx_byte <= '0;
      r_timeout_err <= 1'b0;
      r_gap_cnt     <= '0;
      r_tmo_cnt     <= '0;
    end else begin
      r_spi_start <= 1'b0;
      if (i_err_clr) r_timeout_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_tx_pop) begin
            r_spi_tx_byte <= w_tx_head;
            r_spi_start   <= 1'b1;
            r_tmo_cnt     <= '0;
            r_state       <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A done arriving on the timeout clk still completes the transfer.
          if (i_spi_done) begin
            r_gap_cnt <= '0;
            r_state   <= (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
          end else if (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            r_timeout_err <= 1'b1;
            r_state       <= ST_IDLE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
          end
        end
        ST_GAP: begin
          if (r_gap_cnt == GW'(GAP_LAST)) begin
            r_state <= ST_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + GW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// tb/tb_spi_xfer_sequencer.sv - directed self-checking bench for spi_xfer_sequencer
module tb_spi_xfer_sequencer;

  logic       clk;
  logic       i_reset;
  logic [7:0] i_tx_data;
  logic       i_tx_valid;
  logic       o_tx_ready;
  logic [7:0] o_rx_data;
  logic       o_rx_valid;
  logic       i_rx_ready;
  logic       o_spi_start;
  logic [7:0] o_spi_tx_byte;
  logic [7:0] i_spi_rx_byte;
  logic       i_spi_done;
  logic       o_busy;
  logic       o_timeout_err;
  logic       i_err_clr;
  logic [3:0] o_tx_level;
  logic [3:0] o_rx_level;

  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         m_delay = 20;
  logic [7:0] m_xor = 8'h00;
  logic       m_en = 1'b1;
  int         start_q[$];
  int         done_q[$];
  logic [7:0] sbyte_q[$];

  spi_xfer_sequencer #(.DEPTH(8), .GAP_CYCLES(2), .TIMEOUT_CYCLES(64)) dut (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .i_tx_data     (i_tx_data),
    .i_tx_valid    (i_tx_valid),
    .o_tx_ready    (o_tx_ready),
    .o_rx_data     (o_rx_data),
    .o_rx_valid    (o_rx_valid),
    .i_rx_ready    (i_rx_ready),
    .o_spi_start   (o_spi_start),
    .o_spi_tx_byte (o_spi_tx_byte),
    .i_spi_rx_byte (i_spi_rx_byte),
    .i_spi_done    (i_spi_done),
    .o_busy        (o_busy),
    .o_timeout_err (o_timeout_err),
    .i_err_clr     (i_err_clr),
    .o_tx_level    (o_tx_level),
    .o_rx_level    (o_rx_level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_spi_start) begin
      start_q.push_back(cyc);
      sbyte_q.push_back(o_spi_tx_byte);
    end
    if (i_spi_done) done_q.push_back(cyc);
  end

  // Model master: replies m_delay clks after the start pulse with tx_byte ^ m_xor.
  initial begin : master
    logic [7:0] b;
    i_spi_done    = 1'b0;
    i_spi_rx_byte = 8'h00;
    forever begin
      @(negedge clk);
      if (o_spi_start && m_en) begin
        b = o_spi_tx_byte;
        repeat (m_delay) @(posedge clk);
        #1;
        i_spi_done    = 1'b1;
        i_spi_rx_byte = b ^ m_xor;
        @(posedge clk);
        #1;
        i_spi_done    = 1'b0;
        i_spi_rx_byte = 8'h00;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic sync_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, output int acc_cyc);
    logic ok;
    ok = 1'b0;
    acc_cyc = -1;
    i_tx_data  = b;
    i_tx_valid = 1'b1;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge clk);
      if (o_tx_ready) begin
        ok = 1'b1;
        acc_cyc = cyc;
      end
      sync_edge();
    end
    i_tx_valid = 1'b0;
    check_eq("send_accept", 32'(ok), 1);
  endtask

  task automatic wait_rx(input int lim);
    for (int k = 0; k < lim && !o_rx_valid; k++) @(negedge clk);
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] e);
    @(negedge clk);
    for (int k = 0; k < 200 && !o_rx_valid; k++) @(negedge clk);
    check_eq({tag, "_valid"}, 32'(o_rx_valid), 1);
    check_eq(tag, 32'(o_rx_data), 32'(e));
    i_rx_ready = 1'b1;
    sync_edge();
    i_rx_ready = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 500 && o_busy; k++) @(negedge clk);
    sync_edge();
  endtask

  task automatic clear_log();
    start_q.delete();
    done_q.delete();
    sbyte_q.delete();
  endtask

  int w;
  int tcyc;

  initial begin
    i_reset    = 1'b1;
    i_tx_data  = 8'h00;
    i_tx_valid = 1'b0;
    i_rx_ready = 1'b0;
    i_err_clr  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    i_reset = 1'b0;

    // Reset state
    @(negedge clk);
    check_eq("rst_start", 32'(o_spi_start), 0);
    check_eq("rst_tx_byte", 32'(o_spi_tx_byte), 0);
    check_eq("rst_timeout_err", 32'(o_timeout_err), 0);
    check_eq("rst_busy", 32'(o_busy), 0);
    check_eq("rst_tx_ready", 32'(o_tx_ready), 1);
    check_eq("rst_rx_valid", 32'(o_rx_valid), 0);
    check_eq("rst_rx_data", 32'(o_rx_data), 0);
    check_eq("rst_tx_level", 32'(o_tx_level), 0);
    check_eq("rst_rx_level", 32'(o_rx_level), 0);
    sync_edge();

    // Single byte: 0xA5 out, 0x3C back after 20 clks
    m_delay = 20;
    m_xor   = 8'h99;
    clear_log();
    send(8'hA5, w);
    wait_rx(100);
    check_eq("t1_starts", 32'(start_q.size()), 1);
    check_eq("t1_latency", 32'(start_q[0] - w), 2);
    check_eq("t1_tx_byte", 32'(sbyte_q[0]), 32'h A5);
    check_eq("t1_rx_valid", 32'(o_rx_valid), 1);
    check_eq("t1_rx_data", 32'(o_rx_data), 32'h3C);
    check_eq("t1_rx_level", 32'(o_rx_level), 1);
    sync_edge();
    pop_expect("t1_pop", 8'h3C);
    @(negedge clk);
    check_eq("t1_rx_empty", 32'(o_rx_valid), 0);
    wait_idle();

    // Burst of 8 with GAP_CYCLES=2
    m_delay = 5;
    m_xor   = 8'h00;
    clear_log();
    for (int i = 0; i < 8; i++) send(8'(i), w);
    for (int k = 0; k < 400 && done_q.size() < 8; k++) @(negedge clk);
    wait_idle();
    check_eq("t2_starts", 32'(start_q.size()), 8);
    check_eq("t2_rx_level", 32'(o_rx_level), 8);
    for (int i = 1; i < 8; i++) begin
      check_eq("t2_gap", 32'(start_q[i] - done_q[i-1] - 1), 3);
    end
    for (int i = 0; i < 8; i++) check_eq("t2_tx_byte", 32'(sbyte_q[i]), i);
    for (int i = 0; i < 8; i++) pop_expect("t2_rx_order", 8'(i));
    wait_idle();

    // Backpressure with RX held, then TX full behaviour
    m_delay = 3;
    clear_log();
    for (int i = 0; i < 10; i++) send(8'h10 + 8'(i), w);
    for (int k = 0; k < 500 && done_q.size() < 8; k++) @(negedge clk);
    repeat (50) @(posedge clk);
    @(negedge clk);
    check_eq("t3_starts_stalled", 32'(start_q.size()), 8);
    check_eq("t3_rx_level", 32'(o_rx_level), 8);
    check_eq("t3_tx_level", 32'(o_tx_level), 2);
    check_eq("t3_busy", 32'(o_busy), 1);
    sync_edge();
    for (int i = 0; i < 6; i++) send(8'h1A + 8'(i), w);
    @(negedge clk);
    check_eq("t3_tx_full_level", 32'(o_tx_level), 8);
    check_eq("t3_tx_ready_full", 32'(o_tx_ready), 0);
    @(posedge clk);
    #1;
    i_tx_valid = 1'b1;
    i_tx_data  = 8'h20;
    i_rx_ready = 1'b1;
    @(negedge clk);
    check_eq("t3_9th_ready", 32'(o_tx_ready), 0);
    check_eq("t3_rx_head", 32'(o_rx_data), 32'h10);
    sync_edge();
    i_rx_ready = 1'b0;
    @(negedge clk);
    check_eq("t3_9th_ignored", 32'(o_tx_level), 8);
    check_eq("t3_pop_cycle_ready", 32'(o_tx_ready), 1);
    sync_edge();
    i_tx_valid = 1'b0;
    @(negedge clk);
    check_eq("t3_pushpop_full", 32'(o_tx_level), 8);
    check_eq("t3_release_start", 32'(o_spi_start), 1);
    check_eq("t3_release_byte", 32'(o_spi_tx_byte), 32'h18);
    repeat (30) @(posedge clk);
    @(negedge clk);
    check_eq("t3_one_release", 32'(start_q.size()), 9);
    check_eq("t3_rx_refull", 32'(o_rx_level), 8);
    sync_edge();
    for (int i = 0; i < 16; i++) pop_expect("t3_rx_order", 8'h11 + 8'(i));
    wait_idle();
    @(negedge clk);
    check_eq("t3_rx_drained", 32'(o_rx_level), 0);
    check_eq("t3_tx_drained", 32'(o_tx_level), 0);
    sync_edge();

    // Timeout: master silent for first byte, second byte still launches
    m_en = 1'b0;
    clear_log();
    send(8'h55, w);
    send(8'h66, w);
    for (int k = 0; k < 50 && start_q.size() < 1; k++) @(negedge clk);
    sync_edge();
    m_en = 1'b1;
    tcyc = -1;
    for (int k = 0; k < 200 && !o_timeout_err; k++) @(negedge clk);
    if (o_timeout_err) tcyc = cyc;
    check_eq("t4_timeout_at", 32'(tcyc - start_q[0]), 64);
    check_eq("t4_no_rx_push", 32'(o_rx_level), 0);
    sync_edge();
    wait_rx(100);
    check_eq("t4_starts", 32'(start_q.size()), 2);
    check_eq("t4_next_byte", 32'(sbyte_q[1]), 32'h66);
    check_eq("t4_rx_data", 32'(o_rx_data), 32'h66);
    check_eq("t4_sticky", 32'(o_timeout_err), 1);
    sync_edge();
    i_err_clr = 1'b1;
    sync_edge();
    i_err_clr = 1'b0;
    @(negedge clk);
    check_eq("t4_err_clr", 32'(o_timeout_err), 0);
    sync_edge();
    pop_expect("t4_pop", 8'h66);
    wait_idle();

    // Reset while waiting on the master; the late done must be ignored
    m_delay = 20;
    clear_log();
    send(8'h77, w);
    repeat (5) @(posedge clk);
    #1;
    i_reset = 1'b1;
    sync_edge();
    i_reset = 1'b0;
    @(negedge clk);
    check_eq("t5_start", 32'(o_spi_start), 0);
    check_eq("t5_tx_byte", 32'(o_spi_tx_byte), 0);
    check_eq("t5_busy", 32'(o_busy), 0);
    check_eq("t5_tx_ready", 32'(o_tx_ready), 1);
    check_eq("t5_rx_valid", 32'(o_rx_valid), 0);
    check_eq("t5_tx_level", 32'(o_tx_level), 0);
    repeat (30) @(posedge clk);
    @(negedge clk);
    check_eq("t5_stray_done_seen", 32'(done_q.size()), 1);
    check_eq("t5_stray_no_push", 32'(o_rx_level), 0);
    check_eq("t5_stray_rx_valid", 32'(o_rx_valid), 0);
    check_eq("t5_stray_busy", 32'(o_busy), 0);
    check_eq("t5_no_restart", 32'(start_q.size()), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
